// File: rtl/dual_rail_word_sender.sv
// dual_rail_word_sender
// Serializes a parallel word LSB first into dual-rail return-to-zero tokens
// (bit1/bit0), separated by all-zero spacers. It samples the downstream
// parity checker's dual-rail verdict at the end of every token. At end of
// word it reports the final verdict and any rail-encoding violation.
// Optional feature macro: DR_SENDER_CHECK_EN builds a local expected-parity
// tracker that drives `mismatch`. Without it, `mismatch` is tied low.
module dual_rail_word_sender #(
    parameter int WIDTH         = 8,
    parameter int HOLD_CYCLES   = 2,
    parameter int SPACER_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             bit1,
    output logic             bit0,
    input  logic             parity1,
    input  logic             parity0,
    output logic             done,
    output logic             even_zeros,
    output logic             rail_error,
    output logic             mismatch
);

    localparam int MAX_CNT = (HOLD_CYCLES > SPACER_CYCLES) ? HOLD_CYCLES : SPACER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPACER_LAST = CNT_W'(SPACER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TOKEN  = 2'd1,
        S_SPACER = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // A legal dual-rail sample has exactly one rail high.
    function automatic logic is_one_hot2(input logic [1:0] v);
        return v[1] ^ v[0];
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_samp;
    logic             r_err_acc;
    logic             r_in_ready;
    logic             r_bit1;
    logic             r_bit0;
    logic             r_done;
    logic             r_even_zeros;
    logic             r_rail_error;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_accept;
    logic             w_tok_last;
    logic             w_enter_done;
    logic [1:0]       w_samp_in;

    assign w_samp_in = {parity1, parity0};

    // Next-state, counter and bit-index sequencing of the token/spacer FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_data_nxt   = r_data;
        w_accept     = 1'b0;
        w_tok_last   = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_TOKEN;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_data_nxt  = in_data;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TOKEN: begin
                if (r_cnt == HOLD_LAST) begin
                    w_tok_last  = 1'b1;
                    w_state_nxt = S_SPACER;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SPACER: begin
                if (r_cnt == SPACER_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == IDX_LAST) begin
                        w_enter_done = 1'b1;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_state_nxt = S_TOKEN;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_data_nxt  = r_data >> 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // State register plus outputs registered from the next state, so rails never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_in_ready <= 1'b1;
            r_bit1     <= 1'b0;
            r_bit0     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_data     <= w_data_nxt;
            r_in_ready <= (w_state_nxt == S_IDLE);
            r_bit1     <= (w_state_nxt == S_TOKEN) &  w_data_nxt[0];
            r_bit0     <= (w_state_nxt == S_TOKEN) & ~w_data_nxt[0];
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    // Parity sampling at the end of each token and end-of-word verdict reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_samp       <= 2'b00;
            r_err_acc    <= 1'b0;
            r_even_zeros <= 1'b0;
            r_rail_error <= 1'b0;
        end else if (w_accept) begin
            r_err_acc    <= 1'b0;
            r_rail_error <= 1'b0;
        end else if (w_tok_last) begin
            r_samp <= w_samp_in;
            if (!is_one_hot2(w_samp_in)) begin
                r_err_acc <= 1'b1;
            end
        end else if (w_enter_done) begin
            r_even_zeros <= r_samp[1];
            r_rail_error <= r_err_acc;
        end
    end

`ifdef DR_SENDER_CHECK_EN
    logic r_exp_odd;
    logic r_mismatch;

    // Expected zero-count parity; odd after an odd number of 0 tokens.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_odd  <= 1'b0;
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_exp_odd  <= 1'b0;
            r_mismatch <= 1'b0;
        end else if (w_tok_last) begin
            r_exp_odd <= r_exp_odd ^ ~r_data[0];
        end else if (w_enter_done) begin
            r_mismatch <= (r_samp[1] != ~r_exp_odd);
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

    assign in_ready   = r_in_ready;
    assign bit1       = r_bit1;
    assign bit0       = r_bit0;
    assign done       = r_done;
    assign even_zeros = r_even_zeros;
    assign rail_error = r_rail_error;

endmodule

// File: tb/tb_dual_rail_word_sender.sv
// Self-checking bench for dual_rail_word_sender with the default parameters.
// A behavioural dual-rail parity checker drives parity1/parity0; a timeline
// model predicts every output on every cycle from the accept time and word.
module tb_dual_rail_word_sender;

    localparam int W    = 8;
    localparam int H    = 2;
    localparam int S    = 1;
    localparam int P    = H + S;
    localparam int DLAT = W * P;
`ifdef DR_SENDER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         bit1, bit0;
    logic         parity1 = 1'b0;
    logic         parity0 = 1'b0;
    logic         done, even_zeros, rail_error, mismatch;

    always #5 clk = ~clk;

    dual_rail_word_sender #(.WIDTH(W), .HOLD_CYCLES(H), .SPACER_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .bit1(bit1), .bit0(bit0), .parity1(parity1),
        .parity0(parity0), .done(done), .even_zeros(even_zeros),
        .rail_error(rail_error), .mismatch(mismatch)
    );

    int checks = 0;
    int failures = 0;

    // checker-model configuration for the current word
    bit cfg_inv = 1'b0;
    int cfg_bad = 99;

    // timeline model state
    int           cyc = 0;
    bit           started = 1'b0;
    bit           m_active = 1'b0;
    int           m_k = 0;
    logic [W-1:0] m_word = '0;
    logic m_ready = 1'b1, m_b1 = 1'b0, m_b0 = 1'b0, m_done = 1'b0;
    logic m_ez = 1'b0, m_re = 1'b0, m_mm = 1'b0;
    logic res_ez, res_re, res_mm;
    int   acc_cnt = 0;
    int   acc_edge = -1;
    int   dut_done_edge = -1;
    int   b1cnt = 0;
    int   b0cnt = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Timeline model: outputs follow from accept edge k and the word alone.
    initial begin
        forever begin
            logic prev_ready;
            int   t, i, zeros;
            bit   even;
            @(posedge clk);
            cyc++;
            prev_ready = m_ready;
            if (reset) begin
                started  = 1'b1;
                m_active = 1'b0;
                m_ready  = 1'b1;
                {m_b1, m_b0, m_done, m_ez, m_re, m_mm} = 6'b0;
            end else begin
                if (prev_ready && in_valid) begin
                    m_active = 1'b1;
                    m_k      = cyc;
                    m_word   = in_data;
                    acc_cnt++;
                    acc_edge = cyc;
                    b1cnt    = 0;
                    b0cnt    = 0;
                    m_re     = 1'b0;
                    m_mm     = 1'b0;
                    zeros    = W - $countones(in_data);
                    even     = (zeros % 2) == 0;
                    res_ez   = (cfg_bad == W - 1) ? 1'b1 : (even ^ cfg_inv);
                    res_re   = (cfg_bad < W);
                    res_mm   = CHK && (res_ez != even);
                end else if (m_active && (cyc - m_k) > DLAT) begin
                    m_active = 1'b0;
                end
                if (m_active) begin
                    t       = cyc - m_k;
                    m_ready = 1'b0;
                    if (t < DLAT) begin
                        i      = t / P;
                        m_b1   = ((t % P) < H) &&  m_word[i];
                        m_b0   = ((t % P) < H) && !m_word[i];
                        m_done = 1'b0;
                    end else begin
                        m_b1   = 1'b0;
                        m_b0   = 1'b0;
                        m_done = 1'b1;
                        m_ez   = res_ez;
                        m_re   = res_re;
                        m_mm   = res_mm;
                    end
                end else begin
                    m_ready = 1'b1;
                    {m_b1, m_b0, m_done} = 3'b0;
                end
            end
        end
    end

    // Behavioural dual-rail parity checker: counts 0 tokens, reports even/odd.
    initial begin
        int ck_cnt, ck_tok;
        bit ck_prev, tok, p1, p0;
        ck_cnt = 0; ck_tok = 0; ck_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ck_cnt = 0; ck_tok = 0; ck_prev = 1'b0;
            end
            tok = (bit1 === 1'b1) || (bit0 === 1'b1);
            if (tok && !ck_prev) begin
                if (bit0 === 1'b1) ck_cnt++;
                ck_tok++;
            end
            ck_prev = tok;
            p1 = ((ck_cnt % 2) == 0) ^ cfg_inv;
            p0 = ~p1;
            if (tok && (ck_tok - 1) == cfg_bad) begin
                p1 = 1'b1;
                p0 = 1'b1;
            end
            parity1 = p1;
            parity0 = p0;
        end
    end

    // Per-cycle compare of every output against the model, plus event monitors.
    initial begin
        forever begin
            logic [6:0] got, exp;
            @(negedge clk);
            if (started) begin
                got = {in_ready, bit1, bit0, done, even_zeros, rail_error, mismatch};
                exp = {m_ready, m_b1, m_b0, m_done, m_ez, m_re, m_mm};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL cycle_cmp cyc=%0d got=%b expected=%b (rdy,b1,b0,done,ez,re,mm)",
                             cyc, got, exp);
                end
                if (done === 1'b1) dut_done_edge = cyc;
                if (bit1 === 1'b1) b1cnt++;
                if (bit0 === 1'b1) b0cnt++;
            end
        end
    end

    task automatic wait_accept(input int prev);
        int n = 0;
        while (acc_cnt == prev && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (acc_cnt == prev) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!m_ready && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] word, input bit inv, input int bad);
        int p;
        @(negedge clk);
        cfg_inv  = inv;
        cfg_bad  = bad;
        in_data  = word;
        in_valid = 1'b1;
        p = acc_cnt;
        wait_accept(p);
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    // Directed scenarios followed by randomized words and resets.
    initial begin
        int first_acc, p, ka;
        repeat (2) @(negedge clk);
        chk("reset_state", int'({in_ready, bit1, bit0, done, even_zeros, rail_error, mismatch}), 64);
        reset = 1'b0;

        send(8'hFF, 1'b0, 99);
        wait_idle();
        chk("ff_done_latency", dut_done_edge - acc_edge, 24);
        chk("ff_bit1_cycles", b1cnt, 16);
        chk("ff_bit0_cycles", b0cnt, 0);
        chk("ff_even_zeros", int'(even_zeros), 1);
        chk("ff_rail_error", int'(rail_error), 0);
        chk("ff_mismatch", int'(mismatch), 0);

        send(8'hFE, 1'b0, 99);
        wait_idle();
        chk("fe_bit0_cycles", b0cnt, 2);
        chk("fe_bit1_cycles", b1cnt, 14);
        chk("fe_even_zeros", int'(even_zeros), 0);
        chk("fe_mismatch", int'(mismatch), 0);

        @(negedge clk);
        in_data  = 8'h00;
        in_valid = 1'b1;
        p = acc_cnt;
        wait_accept(p);
        first_acc = acc_edge;
        in_data = 8'h01;
        p = acc_cnt;
        wait_accept(p);
        in_valid = 1'b0;
        chk("b2b_accept_gap", acc_edge - first_acc, 26);
        chk("zeros8_even_zeros", int'(even_zeros), 1);
        wait_idle();
        chk("seven_zeros_even", int'(even_zeros), 0);

        send(8'hA5, 1'b0, 3);
        wait_idle();
        chk("bad_tok_rail_error", int'(rail_error), 1);
        chk("bad_tok_even_zeros", int'(even_zeros), 1);
        send(8'h3C, 1'b0, 99);
        chk("rail_error_cleared", int'(rail_error), 0);
        wait_idle();

        send(8'hFF, 1'b1, 99);
        wait_idle();
        chk("inv_even_zeros", int'(even_zeros), 0);
        chk("inv_mismatch", int'(mismatch), int'(CHK));

        send(8'h5A, 1'b0, 99);
        ka = acc_edge;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_rails", int'({bit1, bit0}), 0);
        chk("rst_flags", int'({done, even_zeros, rail_error, mismatch}), 0);
        repeat (30) @(negedge clk);
        chk("rst_no_done", int'(dut_done_edge < ka), 1);

        for (int n = 0; n < 25; n++) begin
            logic [W-1:0] wd;
            bit inv;
            int bad;
            wd  = W'($urandom);
            inv = ($urandom_range(0, 7) == 0);
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : 99;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(wd, inv, bad);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 22)) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_rail_word_sender.md
# dual_rail_word_sender

Clocked transmitter that serializes a parallel word, LSB first, into dual-rail return-to-zero tokens on `bit1`/`bit0`. It drives the even-zeroes parity checker and samples that checker's dual-rail parity rails after each token. At end of word it reports the checker's final verdict, any rail-encoding violations and, optionally, a comparison against a locally computed expected parity. It sits between a synchronous producer and the asynchronous dual-rail parity checker, and serves as the stimulus source for that checker.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; ≥1.
- `HOLD_CYCLES`, 2: cycles each data token is held; ≥1.
- `SPACER_CYCLES`, 1: cycles of all-zero spacer after each token; ≥1.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  sender can accept a word (IDLE only).
- `in_data`  in  WIDTH  word to send; bit 0 sent first.
- `bit1`  out  1  dual-rail data rail, logical 1.
- `bit0`  out  1  dual-rail data rail, logical 0.
- `parity1`  in  1  checker rail: zeros received so far is even.
- `parity0`  in  1  checker rail: zeros received so far is odd.
- `done`  out  1  one-cycle pulse; result outputs valid.
- `even_zeros`  out  1  final sampled verdict (1 = `parity1` was set).
- `rail_error`  out  1  a parity sample was not one-hot during the word.
- `mismatch`  out  1  `even_zeros` differs from the expected value (see Configuration).

## Operation
- Handshake: accept when `in_valid && in_ready` at a rising edge. Capture `in_data`; clear `rail_error`, `mismatch` and the local zero-count parity.
- FSM states:
  - IDLE: `in_ready`=1; rails 0.
  - TOKEN: drive the current bit one-hot (`bit1`=d, `bit0`=~d) for HOLD_CYCLES.
  - SPACER: rails 0 for SPACER_CYCLES.
  - DONE: `done`=1 for one cycle.
- Transitions:
  - IDLE → TOKEN on accept.
  - TOKEN → SPACER after the hold counter expires.
  - SPACER → TOKEN (next bit) when its counter expires and bits remain.
  - SPACER → DONE when its counter expires after bit WIDTH-1.
  - DONE → IDLE unconditionally.
- Never drive `bit1` and `bit0` high together. Only spacer (00) separates tokens.
- Sampling: on the last TOKEN cycle, register {`parity1`,`parity0`}. If the sample is not exactly one-hot, set sticky `rail_error`. The sample from the final token sets `even_zeros` = sampled `parity1`.
- Expected parity: toggles once per 0 bit sent. Starts at 0, which means even.
- `even_zeros`, `rail_error` and `mismatch` hold their values from DONE until the next accept.
- `in_data` changes after accept have no effect.

## Timing
- Reset values: `in_ready`=1, `bit1`=0, `bit0`=0, `done`=0, `even_zeros`=0, `rail_error`=0, `mismatch`=0; FSM in IDLE; all counters 0.
- All outputs are registered.
- Accept at edge k:
  - first token visible at cycle k+1;
  - token i occupies cycles k+1+i·(H+S) .. k+i·(H+S)+H, where H = HOLD_CYCLES and S = SPACER_CYCLES;
  - `done` is high in cycle k+1+WIDTH·(H+S).
- Next accept possible one cycle after `done`, when IDLE is re-entered.
- Reset mid-word: on the next edge, rails go to 0, the FSM enters IDLE and all flags clear. No partial `done` is issued.
- Reset has priority over `in_valid` on the same edge.
- `in_valid` asserted outside IDLE is ignored; the producer must hold it.

## Configuration
- `DR_SENDER_CHECK_EN` defined: the local expected-parity tracker is built. `mismatch` = (`even_zeros` ≠ expected), registered at DONE.
- Not defined: the tracker is removed and `mismatch` is tied to 0. All other behaviour is identical.

## Test plan
Defaults throughout (WIDTH=8, H=2, S=1); the bench models a correct checker.
- Accept 8'hFF at edge 0 → `bit1` high in cycles 1–2, 4–5, …; `done` at cycle 25; `even_zeros`=1; `rail_error`=0; `mismatch`=0.
- Send 8'hFE → `bit0` high in cycles 1–2 only; `even_zeros`=0; `mismatch`=0.
- Send 8'h00 (eight zeros) → `even_zeros`=1. Then send 8'h01 with `in_valid` held high → second accept on the first IDLE cycle after `done`; result `even_zeros`=0 (seven zeros).
- Bench drives `parity1`=`parity0`=1 during token 3 → `rail_error`=1 at `done`, cleared at the next accept.
- With `DR_SENDER_CHECK_EN` and the checker model inverting its verdict on 8'hFF → `even_zeros`=0 and `mismatch`=1. Without the macro → `mismatch`=0.
- Assert `reset` at cycle 10 of a word → rails 0 and `in_ready`=1 from cycle 11; no `done` pulse; all flags 0.
